// File: rtl/gmii_tx_frame_monitor.sv
// Passive GMII transmit-stream checker: preamble/SFD, length, IPG and fifo cross-checks,
// one result pulse per frame plus saturating link statistics.
`timescale 1ns/1ps
module gmii_tx_frame_monitor #(
  parameter int PRE_LEN = 7,
  parameter int PKT_MIN = 64,
  parameter int PKT_MAX = 1600,
  parameter int IPG_MIN = 7,
  parameter int CNT_W   = 32
) (
  input  logic             gmii_tx_clk,
  input  logic             rst,
  input  logic [7:0]       gmii_data_in,
  input  logic             gmii_en_in,
  input  logic [15:0]      length_in,
  input  logic             crc_error_in,
  input  logic             stat_clear,
  output logic             frame_done,
  output logic [15:0]      frame_len,
  output logic [5:0]       frame_status,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] byte_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [15:0]      min_ipg
);

  localparam logic [2:0] S_SYNC = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_PRE  = 3'd2;
  localparam logic [2:0] S_BODY = 3'd3;
  localparam logic [2:0] S_SKIP = 3'd4;

  localparam logic [15:0] PRE_LEN_W = 16'(PRE_LEN);
  localparam logic [15:0] PKT_MIN_W = 16'(PKT_MIN);
  localparam logic [15:0] PKT_MAX_W = 16'(PKT_MAX);
  localparam logic [15:0] IPG_MIN_W = 16'(IPG_MIN);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add_cnt(input logic [CNT_W-1:0] a,
                                                  input logic [15:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  logic [2:0]  state;
  logic [15:0] pre_idx;
  logic [15:0] tot_cnt;
  logic [15:0] body_cnt;
  logic [15:0] ipg_cnt;
  logic [15:0] gap_cap;
  logic [15:0] len_cap;
  logic        crc_cap;
  logic        pre_err_r;
  logic        ipg_chk;
  logic        have_prev;

  logic        is_pre;
  logic        is_sfd;
  logic        frame_end;
  logic [15:0] end_len;
  logic        end_pre;
  logic        end_runt;
  logic        end_giant;
  logic        end_ipg;
  logic        end_lm;
  logic [5:0]  end_status;

  assign is_pre = (gmii_data_in == 8'h55);
  assign is_sfd = (gmii_data_in == 8'hD5);

  // A frame that never reached BODY (bad byte, or en dropped inside the preamble) reports no length.
  assign frame_end  = !gmii_en_in && (state == S_PRE || state == S_BODY || state == S_SKIP);
  assign end_len    = (state == S_BODY) ? body_cnt : 16'd0;
  assign end_pre    = pre_err_r || (state != S_BODY);
  assign end_runt   = !end_pre && (end_len < PKT_MIN_W);
  assign end_giant  = !end_pre && (end_len > PKT_MAX_W);
  assign end_ipg    = ipg_chk && (gap_cap < IPG_MIN_W);
  assign end_lm     = (tot_cnt != len_cap);
  assign end_status = {crc_cap, end_lm, end_ipg, end_giant, end_runt, end_pre};

  always_ff @(posedge gmii_tx_clk) begin
    if (rst) begin
      state        <= S_SYNC;
      pre_idx      <= '0;
      tot_cnt      <= '0;
      body_cnt     <= '0;
      ipg_cnt      <= '0;
      gap_cap      <= '0;
      len_cap      <= '0;
      crc_cap      <= 1'b0;
      pre_err_r    <= 1'b0;
      ipg_chk      <= 1'b0;
      have_prev    <= 1'b0;
      frame_done   <= 1'b0;
      frame_len    <= '0;
      frame_status <= '0;
      frame_cnt    <= '0;
      byte_cnt     <= '0;
      err_cnt      <= '0;
      min_ipg      <= 16'hFFFF;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_SYNC: begin
          if (!gmii_en_in) begin
            state   <= S_IDLE;
            ipg_cnt <= 16'd1;
          end
        end
        S_IDLE: begin
          if (gmii_en_in) begin
            // First en-high cycle: byte is preamble index 0; fifo sideband and gap are captured here.
            tot_cnt   <= 16'd1;
            body_cnt  <= '0;
            pre_idx   <= 16'd1;
            len_cap   <= length_in;
            crc_cap   <= crc_error_in;
            gap_cap   <= ipg_cnt;
            ipg_chk   <= have_prev;
            have_prev <= 1'b1;
            if (is_sfd) begin
              state     <= S_BODY;
              pre_err_r <= (PRE_LEN_W != 16'd0);
            end else if (is_pre) begin
              state     <= S_PRE;
              pre_err_r <= 1'b0;
            end else begin
              state     <= S_SKIP;
              pre_err_r <= 1'b1;
            end
          end else begin
            ipg_cnt <= sat_inc16(ipg_cnt);
          end
        end
        S_PRE: begin
          if (gmii_en_in) begin
            tot_cnt <= sat_inc16(tot_cnt);
            if (is_sfd) begin
              state     <= S_BODY;
              pre_err_r <= (pre_idx != PRE_LEN_W);
            end else if (is_pre) begin
              pre_idx <= sat_inc16(pre_idx);
            end else begin
              state     <= S_SKIP;
              pre_err_r <= 1'b1;
            end
          end
        end
        S_BODY: begin
          if (gmii_en_in) begin
            tot_cnt  <= sat_inc16(tot_cnt);
            body_cnt <= sat_inc16(body_cnt);
          end
        end
        S_SKIP: begin
          if (gmii_en_in) tot_cnt <= sat_inc16(tot_cnt);
        end
        default: state <= S_SYNC;
      endcase

      // The frame-ending en-low cycle is already the first cycle of the next gap.
      if (frame_end) begin
        state        <= S_IDLE;
        ipg_cnt      <= 16'd1;
        frame_done   <= 1'b1;
        frame_len    <= end_len;
        frame_status <= end_status;
      end

      if (stat_clear) begin
        frame_cnt <= '0;
        byte_cnt  <= '0;
        err_cnt   <= '0;
        min_ipg   <= 16'hFFFF;
      end else if (frame_end) begin
        frame_cnt <= sat_add_cnt(frame_cnt, 16'd1);
        byte_cnt  <= sat_add_cnt(byte_cnt, end_len);
        if (end_status != 6'd0) err_cnt <= sat_add_cnt(err_cnt, 16'd1);
        if (ipg_chk && (gap_cap < min_ipg)) min_ipg <= gap_cap;
      end
    end
  end

endmodule

// File: tb/tb_gmii_tx_frame_monitor.sv
// Bench for gmii_tx_frame_monitor: directed scenarios plus randomized frames checked
// against a frame-level reference model built from the byte list of each frame.
`timescale 1ns/1ps
module tb_gmii_tx_frame_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data = 8'h00;
  logic        en = 1'b0;
  logic [15:0] length_in = 16'h0;
  logic        crc_error_in = 1'b0;
  logic        stat_clear = 1'b0;
  logic        frame_done;
  logic [15:0] frame_len;
  logic [5:0]  frame_status;
  logic [31:0] frame_cnt, byte_cnt, err_cnt;
  logic [15:0] min_ipg;

  gmii_tx_frame_monitor dut (
    .gmii_tx_clk (clk),
    .rst         (rst),
    .gmii_data_in(data),
    .gmii_en_in  (en),
    .length_in   (length_in),
    .crc_error_in(crc_error_in),
    .stat_clear  (stat_clear),
    .frame_done  (frame_done),
    .frame_len   (frame_len),
    .frame_status(frame_status),
    .frame_cnt   (frame_cnt),
    .byte_cnt    (byte_cnt),
    .err_cnt     (err_cnt),
    .min_ipg     (min_ipg)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  fbytes[$];
  bit          m_first;
  int          m_gap;
  logic [31:0] m_fc, m_bc, m_ec;
  logic [15:0] m_min;

  logic        o_early, o_done, o_after;
  logic [15:0] o_len, o_min;
  logic [5:0]  o_st;
  logic [31:0] o_fc, o_bc, o_ec;
  logic [15:0] e_len;
  logic [5:0]  e_st;

  task automatic model_reset();
    m_first = 1'b1;
    m_gap   = 0;
    m_fc    = 0;
    m_bc    = 0;
    m_ec    = 0;
    m_min   = 16'hFFFF;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    stat_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
  endtask

  // pre_n preamble bytes (0x55, or 0xAA at bad_idx), then 0xD5, then body_n random bytes
  task automatic build(input int pre_n, input int bad_idx, input int body_n);
    fbytes.delete();
    for (int i = 0; i < pre_n; i++) fbytes.push_back((i == bad_idx) ? 8'hAA : 8'h55);
    fbytes.push_back(8'hD5);
    for (int i = 0; i < body_n; i++) fbytes.push_back(8'($urandom));
  endtask

  // Drives fbytes as one frame followed by gap_after en-low cycles, captures the DUT result
  // and computes the expected result from the frame-level rules.
  task automatic send(input logic [15:0] len_in, input logic crc, input int gap_after,
                      input bit clr);
    int n, k;
    bit pe;
    n = fbytes.size();
    k = 0;
    while (k < n && fbytes[k] == 8'h55) k++;
    if (k < n && fbytes[k] == 8'hD5) begin
      pe = (k != 7);
      e_len = 16'(n - k - 1);
    end else begin
      pe = 1'b1;
      e_len = 16'd0;
    end
    e_st = {crc, (16'(n) != len_in), (!m_first && m_gap < 7),
            (!pe && e_len > 16'd1600), (!pe && e_len < 16'd64), pe};
    for (int i = 0; i < n; i++) begin
      en = 1'b1;
      data = fbytes[i];
      length_in = (i == 0) ? len_in : 16'($urandom);
      crc_error_in = (i == 0) ? crc : 1'($urandom);
      @(posedge clk);
      #1;
    end
    en = 1'b0;
    data = 8'($urandom);
    stat_clear = clr;
    o_early = frame_done;
    @(posedge clk);
    #1;
    stat_clear = 1'b0;
    if (clr) begin
      m_fc = 0; m_bc = 0; m_ec = 0; m_min = 16'hFFFF;
    end else begin
      m_fc = m_fc + 1;
      m_bc = m_bc + 32'(e_len);
      if (e_st != 6'd0) m_ec = m_ec + 1;
      if (!m_first && 16'(m_gap) < m_min) m_min = 16'(m_gap);
    end
    o_done = frame_done; o_len = frame_len; o_st = frame_status;
    o_fc = frame_cnt; o_bc = byte_cnt; o_ec = err_cnt; o_min = min_ipg;
    o_after = 1'b0;
    for (int j = 1; j < gap_after; j++) begin
      @(posedge clk);
      #1;
      if (j == 1) o_after = frame_done;
    end
    m_first = 1'b0;
    m_gap = gap_after;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %0b want 0", frame_done); end
    n_cmp++; if (frame_len !== 16'd0) begin n_bad++; $display("FAIL reset_len got %0d want 0", frame_len); end
    n_cmp++; if (frame_status !== 6'd0) begin n_bad++; $display("FAIL reset_status got %0h want 0", frame_status); end
    n_cmp++; if (frame_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
    n_cmp++; if (byte_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_byte_cnt got %0d want 0", byte_cnt); end
    n_cmp++; if (err_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
    n_cmp++; if (min_ipg !== 16'hFFFF) begin n_bad++; $display("FAIL reset_min_ipg got %0h want ffff", min_ipg); end
  endtask

  task automatic test_basic();
    do_reset();
    for (int f = 0; f < 2; f++) begin
      build(7, -1, 64);
      send(16'd72, 1'b0, 12, 1'b0);
      n_cmp++; if (o_early !== 1'b0) begin n_bad++; $display("FAIL basic_early f%0d got %0b want 0", f, o_early); end
      n_cmp++; if (o_done !== 1'b1) begin n_bad++; $display("FAIL basic_done f%0d got %0b want 1", f, o_done); end
      n_cmp++; if (o_after !== 1'b0) begin n_bad++; $display("FAIL basic_pulse_width f%0d got %0b want 0", f, o_after); end
      n_cmp++; if (o_len !== 16'd64) begin n_bad++; $display("FAIL basic_len f%0d got %0d want 64", f, o_len); end
      n_cmp++; if (o_st !== 6'h00) begin n_bad++; $display("FAIL basic_status f%0d got %0h want 0", f, o_st); end
    end
    n_cmp++; if (o_fc !== 32'd2) begin n_bad++; $display("FAIL basic_frame_cnt got %0d want 2", o_fc); end
    n_cmp++; if (o_bc !== 32'd128) begin n_bad++; $display("FAIL basic_byte_cnt got %0d want 128", o_bc); end
    n_cmp++; if (o_min !== 16'd12) begin n_bad++; $display("FAIL basic_min_ipg got %0d want 12", o_min); end
    n_cmp++; if (frame_len !== 16'd64) begin n_bad++; $display("FAIL basic_len_hold got %0d want 64", frame_len); end
  endtask

  task automatic test_runt_giant();
    do_reset();
    build(7, -1, 63);
    send(16'd71, 1'b0, 12, 1'b0);
    n_cmp++; if (o_st !== 6'h02) begin n_bad++; $display("FAIL runt_status got %0h want 02", o_st); end
    n_cmp++; if (o_len !== 16'd63) begin n_bad++; $display("FAIL runt_len got %0d want 63", o_len); end
    build(7, -1, 1601);
    send(16'd1609, 1'b0, 12, 1'b0);
    n_cmp++; if (o_st !== 6'h04) begin n_bad++; $display("FAIL giant_status got %0h want 04", o_st); end
    n_cmp++; if (o_len !== 16'd1601) begin n_bad++; $display("FAIL giant_len got %0d want 1601", o_len); end
    n_cmp++; if (o_ec !== 32'd2) begin n_bad++; $display("FAIL runt_giant_err_cnt got %0d want 2", o_ec); end
  endtask

  task automatic test_ipg();
    do_reset();
    build(7, -1, 64);
    send(16'd72, 1'b0, 5, 1'b0);
    n_cmp++; if (o_st !== 6'h00) begin n_bad++; $display("FAIL ipg_first_exempt got %0h want 00", o_st); end
    n_cmp++; if (o_min !== 16'hFFFF) begin n_bad++; $display("FAIL ipg_first_min got %0h want ffff", o_min); end
    build(7, -1, 64);
    send(16'd72, 1'b0, 1, 1'b0);
    n_cmp++; if (o_st !== 6'h08) begin n_bad++; $display("FAIL ipg_gap5_status got %0h want 08", o_st); end
    n_cmp++; if (o_min !== 16'd5) begin n_bad++; $display("FAIL ipg_gap5_min got %0d want 5", o_min); end
    build(7, -1, 64);
    send(16'd72, 1'b0, 12, 1'b0);
    n_cmp++; if (o_done !== 1'b1) begin n_bad++; $display("FAIL ipg_b2b_done got %0b want 1", o_done); end
    n_cmp++; if (o_st !== 6'h08) begin n_bad++; $display("FAIL ipg_gap1_status got %0h want 08", o_st); end
    n_cmp++; if (o_min !== 16'd1) begin n_bad++; $display("FAIL ipg_gap1_min got %0d want 1", o_min); end
  endtask

  task automatic test_preamble();
    do_reset();
    build(6, -1, 64);
    send(16'd71, 1'b0, 12, 1'b0);
    n_cmp++; if (o_st !== 6'h01) begin n_bad++; $display("FAIL pre_short_status got %0h want 01", o_st); end
    n_cmp++; if (o_len !== 16'd64) begin n_bad++; $display("FAIL pre_short_len got %0d want 64", o_len); end
    build(7, 2, 64);
    send(16'd72, 1'b0, 12, 1'b0);
    n_cmp++; if (o_st !== 6'h01) begin n_bad++; $display("FAIL pre_bad_status got %0h want 01", o_st); end
    n_cmp++; if (o_len !== 16'd0) begin n_bad++; $display("FAIL pre_bad_len got %0d want 0", o_len); end
    n_cmp++; if (o_bc !== 32'd64) begin n_bad++; $display("FAIL pre_byte_cnt got %0d want 64", o_bc); end
  endtask

  task automatic test_reset_mid();
    int seen;
    do_reset();
    build(7, -1, 64);
    for (int i = 0; i < fbytes.size(); i++) begin
      en = 1'b1;
      data = fbytes[i];
      length_in = 16'd72;
      rst = (i == 30);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    en = 1'b0;
    model_reset();
    seen = 0;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk);
      #1;
      if (frame_done) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midrst_no_done got %0d pulses want 0", seen); end
    n_cmp++; if (frame_cnt !== 32'd0) begin n_bad++; $display("FAIL midrst_frame_cnt got %0d want 0", frame_cnt); end
    build(7, -1, 64);
    send(16'd72, 1'b0, 12, 1'b0);
    n_cmp++; if (o_done !== 1'b1) begin n_bad++; $display("FAIL midrst_next_done got %0b want 1", o_done); end
    n_cmp++; if (o_st !== 6'h00) begin n_bad++; $display("FAIL midrst_next_status got %0h want 00", o_st); end
    n_cmp++; if (o_fc !== 32'd1) begin n_bad++; $display("FAIL midrst_next_frame_cnt got %0d want 1", o_fc); end
    n_cmp++; if (o_bc !== 32'd64) begin n_bad++; $display("FAIL midrst_next_byte_cnt got %0d want 64", o_bc); end
  endtask

  task automatic test_len_crc_clear();
    do_reset();
    build(7, -1, 64);
    send(16'd73, 1'b0, 12, 1'b0);
    n_cmp++; if (o_st !== 6'h10) begin n_bad++; $display("FAIL lenmm_status got %0h want 10", o_st); end
    build(7, -1, 64);
    send(16'd72, 1'b1, 12, 1'b0);
    n_cmp++; if (o_st !== 6'h20) begin n_bad++; $display("FAIL crc_status got %0h want 20", o_st); end
    n_cmp++; if (o_ec !== 32'd2) begin n_bad++; $display("FAIL crc_err_cnt got %0d want 2", o_ec); end
    build(7, -1, 64);
    send(16'd72, 1'b0, 12, 1'b1);
    n_cmp++; if (o_done !== 1'b1) begin n_bad++; $display("FAIL clear_done got %0b want 1", o_done); end
    n_cmp++; if (o_len !== 16'd64) begin n_bad++; $display("FAIL clear_len got %0d want 64", o_len); end
    n_cmp++; if (o_fc !== 32'd0) begin n_bad++; $display("FAIL clear_frame_cnt got %0d want 0", o_fc); end
    n_cmp++; if (o_bc !== 32'd0) begin n_bad++; $display("FAIL clear_byte_cnt got %0d want 0", o_bc); end
    n_cmp++; if (o_ec !== 32'd0) begin n_bad++; $display("FAIL clear_err_cnt got %0d want 0", o_ec); end
    n_cmp++; if (o_min !== 16'hFFFF) begin n_bad++; $display("FAIL clear_min_ipg got %0h want ffff", o_min); end
  endtask

  task automatic test_random();
    int pre_n, bad, body, gap, n;
    logic [15:0] li;
    logic crc;
    bit clr;
    do_reset();
    for (int f = 0; f < 14; f++) begin
      body  = ($urandom_range(9) == 0) ? int'($urandom_range(1610, 1601)) : int'($urandom_range(200, 40));
      pre_n = ($urandom_range(3) == 0) ? int'($urandom_range(9, 5)) : 7;
      bad   = ($urandom_range(5) == 0) ? int'($urandom_range(pre_n - 1, 0)) : -1;
      gap   = int'($urandom_range(15, 1));
      n     = pre_n + 1 + body;
      li    = ($urandom_range(4) == 0) ? 16'(n + 1) : 16'(n);
      crc   = ($urandom_range(4) == 0);
      clr   = ($urandom_range(7) == 0);
      build(pre_n, bad, body);
      send(li, crc, gap, clr);
      n_cmp++; if (o_done !== 1'b1) begin n_bad++; $display("FAIL rnd_done f%0d got %0b want 1", f, o_done); end
      n_cmp++; if (o_early !== 1'b0) begin n_bad++; $display("FAIL rnd_early f%0d got %0b want 0", f, o_early); end
      n_cmp++; if (o_len !== e_len) begin n_bad++; $display("FAIL rnd_len f%0d got %0d want %0d", f, o_len, e_len); end
      n_cmp++; if (o_st !== e_st) begin n_bad++; $display("FAIL rnd_status f%0d got %0h want %0h", f, o_st, e_st); end
      n_cmp++; if (o_fc !== m_fc) begin n_bad++; $display("FAIL rnd_frame_cnt f%0d got %0d want %0d", f, o_fc, m_fc); end
      n_cmp++; if (o_bc !== m_bc) begin n_bad++; $display("FAIL rnd_byte_cnt f%0d got %0d want %0d", f, o_bc, m_bc); end
      n_cmp++; if (o_ec !== m_ec) begin n_bad++; $display("FAIL rnd_err_cnt f%0d got %0d want %0d", f, o_ec, m_ec); end
      n_cmp++; if (o_min !== m_min) begin n_bad++; $display("FAIL rnd_min_ipg f%0d got %0d want %0d", f, o_min, m_min); end
      if (gap > 1) begin
        n_cmp++; if (o_after !== 1'b0) begin n_bad++; $display("FAIL rnd_pulse_width f%0d got %0b want 0", f, o_after); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_runt_giant();
    test_ipg();
    test_preamble();
    test_reset_mid();
    test_len_crc_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1, "time limit");
  end

endmodule
